// File: rtl/wb_port_arbiter_if.sv
// Request/writeback bundle between the functional-unit result stages and the
// register-file write port arbiter.
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                        hold;
    logic [4:0]                  req_valid;
    logic [4:0]                  req_ready;
    logic [5*REG_ADDR_WIDTH-1:0] req_rd;
    logic [5*DATA_WIDTH-1:0]     req_data;
    logic                        wb_we;
    logic [REG_ADDR_WIDTH-1:0]   wb_rd;
    logic [DATA_WIDTH-1:0]       wb_data;
    logic [2:0]                  wb_sel;
    logic [4:0]                  starve;

    modport master (
        output hold, req_valid, req_rd, req_data,
        input  req_ready, wb_we, wb_rd, wb_data, wb_sel, starve
    );

    modport slave (
        input  hold, req_valid, req_rd, req_data,
        output req_ready, wb_we, wb_rd, wb_data, wb_sel, starve
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Five-source register-file write port arbiter with starvation override.
// Base policy is fixed priority; define WB_PORT_ARBITER_RR_EN for round robin.
module wb_port_arbiter_lane #(
    parameter int MAX_WAIT = 7
) (
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    input  logic xfer,
    output logic starve
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!valid || xfer)
            cnt_d = '0;
        else if (cnt_q != CW'(MAX_WAIT))
            cnt_d = cnt_q + CW'(1);
    end

    // starve is registered from the next count so it lines up with cnt_q
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            starve <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            starve <= (cnt_d == CW'(MAX_WAIT));
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_WAIT       = 7
) (
    input logic              clk,
    input logic              rstn,
    wb_port_arbiter_if.slave bus
);
    localparam int N  = 5;
    localparam int DW = DATA_WIDTH;
    localparam int AW = REG_ADDR_WIDTH;

    logic [N-1:0]  gnt, stv, xfer;
    logic          found;
    logic [2:0]    gsel;
    logic [AW-1:0] grd;
    logic [DW-1:0] gdata;

    logic          we_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] data_q;
    logic [2:0]    sel_q;

`ifdef WB_PORT_ARBITER_RR_EN
    logic [2:0] rr_ptr;
    logic [3:0] ridx;
`endif

    always_comb begin
        gnt   = '0;
        found = 1'b0;
`ifdef WB_PORT_ARBITER_RR_EN
        ridx  = '0;
`endif
        for (int i = 0; i < N; i++) begin
            if (!found && bus.req_valid[i] && stv[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
`ifdef WB_PORT_ARBITER_RR_EN
        // search p, p+1, ... wrapping 4 -> 0
        for (int k = 0; k < N; k++) begin
            ridx = {1'b0, rr_ptr} + 4'(k);
            if (ridx >= 4'(N))
                ridx = ridx - 4'(N);
            if (!found && bus.req_valid[ridx[2:0]]) begin
                gnt[ridx[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && bus.req_valid[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
`endif
        if (bus.hold || !rstn)
            gnt = '0;
    end

    assign bus.req_ready = gnt;
    assign xfer          = gnt & bus.req_valid;

    always_comb begin
        gsel  = '0;
        grd   = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gsel  = 3'(i);
                grd   = bus.req_rd[i*AW +: AW];
                gdata = bus.req_data[i*DW +: DW];
            end
        end
    end

    wb_port_arbiter_lane #(.MAX_WAIT(MAX_WAIT)) u_lane [N-1:0] (
        .clk    (clk),
        .rstn   (rstn),
        .valid  (bus.req_valid),
        .xfer   (xfer),
        .starve (stv)
    );

    assign bus.starve = stv;

`ifdef WB_PORT_ARBITER_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rr_ptr <= '0;
        else if (|xfer)
            rr_ptr <= (gsel == 3'd4) ? 3'd0 : gsel + 3'd1;
    end
`endif

    // x0 writes still complete the handshake but never assert the enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (|xfer) begin
                we_q   <= (grd != '0);
                rd_q   <= grd;
                data_q <= gdata;
                sel_q  <= gsel;
            end
        end
    end

    assign bus.wb_we   = we_q;
    assign bus.wb_rd   = rd_q;
    assign bus.wb_data = data_q;
    assign bus.wb_sel  = sel_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 5;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [2:0]    sel;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    wb_port_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MAX_WAIT(7)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int  gq[$];
    wr_t wq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_prev = 1'b0;

    logic [N-1:0][AW-1:0] rd_v;
    logic [N-1:0][DW-1:0] dat_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic h, input logic [N-1:0] v, input int g, input bit pw = 1'b1);
        wr_t w;
        bus.hold      = h;
        bus.req_valid = v;
        bus.req_rd    = rd_v;
        bus.req_data  = dat_v;
        if (g >= 0) begin
            gq.push_back(g);
            if (pw) begin
                w.we   = (rd_v[g] != '0);
                w.rd   = rd_v[g];
                w.data = dat_v[g];
                w.sel  = 3'(g);
                wq.push_back(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // monitor
    initial begin
        int  g;
        wr_t w;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (mon_prev) begin
                    if (wq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexp_write we=%b rd=%0d data=%h sel=%0d expected none",
                                 bus.wb_we, bus.wb_rd, bus.wb_data, bus.wb_sel);
                    end else begin
                        w = wq.pop_front();
                        chk("write", {bus.wb_we, bus.wb_rd, bus.wb_data, bus.wb_sel}, w);
                    end
                end else begin
                    chk("idle_we", bus.wb_we, 1'b0);
                end
                if (|bus.req_ready) begin
                    if (gq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexp_grant ready=%b expected none", bus.req_ready);
                    end else begin
                        g = gq.pop_front();
                        chk("grant", bus.req_ready, 64'(5'b1 << g));
                    end
                end
                mon_prev = |(bus.req_ready & bus.req_valid);
            end else begin
                mon_prev = 1'b0;
            end
        end
    end

    initial begin
        rstn          = 1'b1;
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        rd_v          = '0;
        dat_v         = '0;
        #2 rstn = 1'b0;
        #10;
        bus.req_valid = 5'b00100;
        #1;
        chk("rst_we",    bus.wb_we, 1'b0);
        chk("rst_rd",    bus.wb_rd, '0);
        chk("rst_data",  bus.wb_data, '0);
        chk("rst_sel",   bus.wb_sel, '0);
        chk("rst_starve", bus.starve, '0);
        chk("rst_ready", bus.req_ready, '0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

`ifdef WB_PORT_ARBITER_RR_EN
        for (int i = 0; i < N; i++) begin
            rd_v[i]  = AW'(10 + i);
            dat_v[i] = 32'hC0DE_0000 + 32'(i);
        end
        for (int k = 0; k < 6; k++)
            cyc(1'b0, 5'b11111, k % 5);
        cyc(1'b0, 5'b00000, -1);
`else
        for (int i = 0; i < N; i++) begin
            rd_v[i]  = AW'(10 + i);
            dat_v[i] = 32'hC0DE_0000 + 32'(i);
        end
        for (int k = 0; k < 3; k++) begin
            dat_v[0] = 32'hF00D_0000 + 32'(k);
            cyc(1'b0, 5'b11111, 0);
        end
        cyc(1'b0, 5'b00000, -1);
`endif

        // single request
        rd_v[2]  = 5'd7;
        dat_v[2] = 32'hDEAD_BEEF;
        cyc(1'b0, 5'b00100, 2);
        cyc(1'b0, 5'b00000, -1);

`ifndef WB_PORT_ARBITER_RR_EN
        // contention: ALU wins until 1 and 4 starve
        rd_v[0]  = 5'd1;
        rd_v[1]  = 5'd2;
        dat_v[1] = 32'h0000_1111;
        rd_v[4]  = 5'd9;
        dat_v[4] = 32'h0000_4444;
        for (int c = 0; c < 7; c++) begin
            dat_v[0] = 32'hA000_0000 + 32'(c);
            cyc(1'b0, 5'b10011, 0);
        end
        chk("starve_7", bus.starve, 5'b10010);
        dat_v[0] = 32'hA000_0007;
        cyc(1'b0, 5'b10011, 1);
        chk("starve_8", bus.starve, 5'b10000);
        cyc(1'b0, 5'b10001, 4);
        cyc(1'b0, 5'b00001, 0);
        cyc(1'b0, 5'b00000, -1);
`endif

        // rd = x0
        rd_v[3]  = 5'd0;
        dat_v[3] = 32'h0000_1234;
        cyc(1'b0, 5'b01000, 3);
        cyc(1'b0, 5'b00000, -1);

        // hold
        rd_v[0]  = 5'd3;
        dat_v[0] = 32'h0000_ABCD;
        for (int c = 0; c < 3; c++) begin
            bus.hold      = 1'b1;
            bus.req_valid = 5'b00001;
            bus.req_rd    = rd_v;
            bus.req_data  = dat_v;
            #1;
            chk("hold_ready", bus.req_ready, '0);
            chk("hold_we", bus.wb_we, 1'b0);
            @(posedge clk);
            #1;
        end
        cyc(1'b0, 5'b00001, 0);
        cyc(1'b0, 5'b00000, -1);

        // reset the cycle after a transfer
        rd_v[1]  = 5'd5;
        dat_v[1] = 32'h0000_0055;
        cyc(1'b0, 5'b00010, 1, 1'b0);
        rstn          = 1'b0;
        bus.req_valid = 5'b00001;
        #1;
        chk("mid_rst_we",     bus.wb_we, 1'b0);
        chk("mid_rst_rd",     bus.wb_rd, '0);
        chk("mid_rst_data",   bus.wb_data, '0);
        chk("mid_rst_sel",    bus.wb_sel, '0);
        chk("mid_rst_starve", bus.starve, '0);
        chk("mid_rst_ready",  bus.req_ready, '0);
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        chk("post_rst_we", bus.wb_we, 1'b0);
        cyc(1'b0, 5'b00001, 0);
        cyc(1'b0, 5'b00000, -1);
        @(posedge clk);
        #1;

        chk("grant_q_empty", 64'(gq.size()), 64'd0);
        chk("write_q_empty", 64'(wq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
